// File: rtl/piso_sel_gen_8_pkg.sv
// Shared definitions for the piso_sel_gen_8 serialiser.
//   - FSM state encodings (IDLE, SHIFT)
//   - width of the per-bit clock prescaler
//   - helpers that map the bit-order parameter to the first/last select index
package piso_sel_gen_8_pkg;

  localparam int unsigned DIV_CNT_W = 8;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  function automatic logic [2:0] sel_first(input bit msb_first);
    return msb_first ? 3'd7 : 3'd0;
  endfunction

  function automatic logic [2:0] sel_last(input bit msb_first);
    return msb_first ? 3'd0 : 3'd7;
  endfunction

endpackage

// File: rtl/mux4to1_12.sv
// 4:1 single-bit multiplexer built from mux_2_12 cells.
//   d : data inputs, d[i] selected when s == i
//   s : 2-bit select
//   y : output
module mux4to1_12 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  logic y_lo;
  logic y_hi;

  mux_2_12 u_lo (.a(d[0]), .b(d[1]), .s(s[0]), .y(y_lo));
  mux_2_12 u_hi (.a(d[2]), .b(d[3]), .s(s[0]), .y(y_hi));
  mux_2_12 u_out (.a(y_lo), .b(y_hi), .s(s[1]), .y(y));

endmodule

// File: rtl/mux8to1_12.sv
// 8:1 single-bit multiplexer built from two mux4to1_12 and one mux_2_12.
//   d : data inputs, d[i] selected when s == i
//   s : 3-bit select
//   y : output
module mux8to1_12 (
  input  logic [7:0] d,
  input  logic [2:0] s,
  output logic       y
);

  logic y_lo;
  logic y_hi;

  mux4to1_12 u_lo (.d(d[3:0]), .s(s[1:0]), .y(y_lo));
  mux4to1_12 u_hi (.d(d[7:4]), .s(s[1:0]), .y(y_hi));
  mux_2_12   u_out (.a(y_lo), .b(y_hi), .s(s[2]), .y(y));

endmodule

// File: rtl/mux_2_12.sv
// 2:1 single-bit multiplexer.
//   a, b : data inputs (a selected when s=0)
//   s    : select
//   y    : output
module mux_2_12 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/piso_sel_gen_8.sv
// 8-bit parallel-in / serial-out sequencer.
// A byte is captured on a load_valid/load_ready handshake, then a 3-bit select
// walks all eight bit positions, each held for DIV clocks. The captured byte
// and the select drive an internal mux8to1_12 whose output is ser_out.
//
// Parameters:
//   DIV       clocks per serial bit (1..255)
//   MSB_FIRST 0: sel counts 0->7, 1: sel counts 7->0
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_data   byte to serialise, sampled only on handshake
//   load_valid  load_data valid
//   load_ready  byte can be accepted this cycle (idle, or last cycle of a frame)
//   sel         current bit index, also usable by an external mux8to1_12
//   ser_out     selected bit while busy, 0 when idle
//   busy        frame in progress
//   frame_done  one-cycle pulse after the last bit period of a frame
module piso_sel_gen_8
  import piso_sel_gen_8_pkg::*;
#(
  parameter int unsigned DIV       = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] load_data,
  input  logic       load_valid,
  output logic       load_ready,
  output logic [2:0] sel,
  output logic       ser_out,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0]           SelFirst = sel_first(MSB_FIRST);
  localparam logic [2:0]           SelLast  = sel_last(MSB_FIRST);
  localparam logic [DIV_CNT_W-1:0] DivTc    = DIV_CNT_W'(DIV - 1);

  logic                 state_q, state_d;
  logic [7:0]           data_q, data_d;
  logic [2:0]           sel_q, sel_d;
  logic [DIV_CNT_W-1:0] div_q, div_d;
  logic                 frame_done_q, frame_done_d;

  logic bit_end;
  logic last_cycle;
  logic accept;
  logic mux_y;

  assign bit_end    = (div_q == DivTc);
  assign last_cycle = (state_q == SHIFT) && (sel_q == SelLast) && bit_end;
  // Ready in the final cycle too, so frames can run back-to-back with no gap.
  assign load_ready = (state_q == IDLE) || last_cycle;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sel_d        = sel_q;
    div_d        = div_q;
    frame_done_d = 1'b0;

    if (state_q == SHIFT) begin
      if (bit_end) begin
        div_d = '0;
        if (sel_q == SelLast) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
          sel_d        = SelFirst;
        end else begin
          sel_d = MSB_FIRST ? sel_q - 3'd1 : sel_q + 3'd1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    // A new capture overrides the end-of-frame return to IDLE.
    if (accept) begin
      state_d = SHIFT;
      data_d  = load_data;
      sel_d   = SelFirst;
      div_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      sel_q        <= SelFirst;
      div_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      div_q        <= div_d;
      frame_done_q <= frame_done_d;
    end
  end

  mux8to1_12 u_bit_mux (
    .d (data_q),
    .s (sel_q),
    .y (mux_y)
  );

  assign busy       = (state_q == SHIFT);
  assign ser_out    = busy & mux_y;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_sel_gen_8.sv
// Bench for piso_sel_gen_8: three instances cover DIV=1/LSB-first, DIV=3/LSB-first
// and DIV=2/MSB-first. Expected per-cycle observations are queued when a load is
// driven and popped/compared one per clock on the falling edge.
module tb_piso_sel_gen_8;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       fd;
    logic       ser;
    logic [2:0] sel;
  } obs_t;

  typedef struct {
    int unsigned idx;
    logic [7:0]  data;
    logic [7:0]  stream;  // stream[k] = k-th bit on the wire
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] ld     [3];
  logic       lv     [3];
  logic       rdy_o  [3];
  logic       busy_o [3];
  logic       fd_o   [3];
  logic       ser_o  [3];
  logic [2:0] sel_o  [3];

  int unsigned div_of [3];
  bit          msb_of [3];

  obs_t q[$];
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_sel_gen_8 #(.DIV(1), .MSB_FIRST(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .load_data(ld[0]), .load_valid(lv[0]),
    .load_ready(rdy_o[0]), .sel(sel_o[0]), .ser_out(ser_o[0]),
    .busy(busy_o[0]), .frame_done(fd_o[0])
  );

  piso_sel_gen_8 #(.DIV(3), .MSB_FIRST(1'b0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .load_data(ld[1]), .load_valid(lv[1]),
    .load_ready(rdy_o[1]), .sel(sel_o[1]), .ser_out(ser_o[1]),
    .busy(busy_o[1]), .frame_done(fd_o[1])
  );

  piso_sel_gen_8 #(.DIV(2), .MSB_FIRST(1'b1)) u_d2m (
    .clk(clk), .rst_n(rst_n), .load_data(ld[2]), .load_valid(lv[2]),
    .load_ready(rdy_o[2]), .sel(sel_o[2]), .ser_out(ser_o[2]),
    .busy(busy_o[2]), .frame_done(fd_o[2])
  );

  function automatic obs_t get_act(input int unsigned idx);
    obs_t o;
    o.rdy  = rdy_o[idx];
    o.busy = busy_o[idx];
    o.fd   = fd_o[idx];
    o.ser  = ser_o[idx];
    o.sel  = sel_o[idx];
    return o;
  endfunction

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got rdy=%b busy=%b fd=%b ser=%b sel=%0d, want rdy=%b busy=%b fd=%b ser=%b sel=%0d",
               name, $time, act.rdy, act.busy, act.fd, act.ser, act.sel,
               exp.rdy, exp.busy, exp.fd, exp.ser, exp.sel);
    end
  endtask

  function automatic logic [2:0] first_sel(input int unsigned idx);
    return msb_of[idx] ? 3'd7 : 3'd0;
  endfunction

  // Queue the observations for cycles 1..8*DIV after a handshake, plus an
  // optional trailing idle cycle carrying the frame_done pulse.
  task automatic push_frame(input int unsigned idx, input logic [7:0] stream,
                            input bit b2b_second, input bit tail_idle);
    obs_t e;
    int unsigned d;
    d = div_of[idx];
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < int'(d); c++) begin
        e.ser  = stream[k];
        e.sel  = msb_of[idx] ? 3'(7 - k) : 3'(k);
        e.busy = 1'b1;
        e.fd   = b2b_second && (k == 0) && (c == 0);
        e.rdy  = (k == 7) && (c == int'(d) - 1);
        q.push_back(e);
      end
    end
    if (tail_idle) begin
      e.ser  = 1'b0;
      e.sel  = first_sel(idx);
      e.busy = 1'b0;
      e.fd   = 1'b1;
      e.rdy  = 1'b1;
      q.push_back(e);
    end
  endtask

  int unsigned cur;

  // Advance one cycle: compare on the falling edge, then step off it to drive.
  task automatic tick();
    obs_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("cycle", get_act(cur), e);
    end
    #1;
  endtask

  task automatic drain();
    for (int g = 0; g < 300 && q.size() > 0; g++) tick();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected cycles left, want 0", q.size());
      q.delete();
    end
  endtask

  vec_t vecs [6];
  obs_t e_idle;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cur   = 0;
    div_of[0] = 1; msb_of[0] = 1'b0;
    div_of[1] = 3; msb_of[1] = 1'b0;
    div_of[2] = 2; msb_of[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld[i] = 8'h00;
      lv[i] = 1'b0;
    end

    vecs[0] = '{idx: 0, data: 8'hA5, stream: 8'hA5};
    vecs[1] = '{idx: 1, data: 8'h81, stream: 8'h81};
    vecs[2] = '{idx: 2, data: 8'hC0, stream: 8'h03};
    vecs[3] = '{idx: 2, data: 8'h01, stream: 8'h80};
    vecs[4] = '{idx: 1, data: 8'h96, stream: 8'h96};
    vecs[5] = '{idx: 0, data: 8'h3C, stream: 8'h3C};

    rst_n = 1'b0;
    #12;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      e_idle = '{rdy: 1'b1, busy: 1'b0, fd: 1'b0, ser: 1'b0, sel: first_sel(i)};
      cmp("reset", get_act(i), e_idle);
    end

    // Table-driven single frames; load_data is scrambled after the handshake.
    foreach (vecs[v]) begin
      cur = vecs[v].idx;
      ld[cur] = vecs[v].data;
      lv[cur] = 1'b1;
      push_frame(cur, vecs[v].stream, 1'b0, 1'b1);
      tick();
      lv[cur] = 1'b0;
      ld[cur] = ~vecs[v].data;
      drain();
      tick();
    end

    // Back-to-back 0xFF then 0x00 with load_valid held high.
    cur = 0;
    ld[0] = 8'hFF;
    lv[0] = 1'b1;
    push_frame(0, 8'hFF, 1'b0, 1'b0);
    push_frame(0, 8'h00, 1'b1, 1'b1);
    tick();
    ld[0] = 8'h00;
    repeat (8) tick();
    lv[0] = 1'b0;
    drain();
    tick();

    // Load offered mid-frame must be refused and leave the stream untouched.
    ld[0] = 8'h0F;
    lv[0] = 1'b1;
    push_frame(0, 8'h0F, 1'b0, 1'b1);
    tick();
    lv[0] = 1'b0;
    tick();
    tick();
    ld[0] = 8'hF0;
    lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    drain();
    tick();

    // Asynchronous reset in cycle 4 of a DIV=3 frame.
    cur = 1;
    ld[1] = 8'h96;
    lv[1] = 1'b1;
    push_frame(1, 8'h96, 1'b0, 1'b1);
    tick();
    lv[1] = 1'b0;
    repeat (3) tick();
    q.delete();
    rst_n = 1'b0;
    #1;
    e_idle = '{rdy: 1'b1, busy: 1'b0, fd: 1'b0, ser: 1'b0, sel: 3'd0};
    cmp("async_reset", get_act(1), e_idle);
    tick();
    tick();
    rst_n = 1'b1;
    q.push_back(e_idle);
    q.push_back(e_idle);
    tick();
    tick();
    ld[1] = 8'h3C;
    lv[1] = 1'b1;
    push_frame(1, 8'h3C, 1'b0, 1'b1);
    tick();
    lv[1] = 1'b0;
    drain();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_sel_gen_8.md
Name: piso_sel_gen_8

Overview:
- 8-bit parallel-in/serial-out sequencer. Captures a byte through a valid/ready handshake, then steps a 3-bit select through all eight bit positions.
- Datapath is one internal mux8to1_12 instance fed by the captured byte and the select counter. The select is also exported for an external mux8to1_12 if needed.
- Sits upstream of the 8:1 mux layer and drives it. It also feeds the serial line / LED bit-output stage.

Parameters:
- DIV, 1, clocks per serial bit (1..255); prescaler terminal count is DIV-1
- MSB_FIRST, 0, 0 = bit 0 first (sel counts 0->7); 1 = bit 7 first (sel counts 7->0)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load_data  input  8  parallel byte to serialise
- load_valid  input  1  load_data valid
- load_ready  output  1  block can accept a byte this cycle
- sel  output  3  current bit index (drives mux8to1_12 s)
- ser_out  output  1  serial bit = data_reg[sel] while busy, 0 when idle
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after last bit period of a frame

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, data_reg=0, sel=first index (0, or 7 if MSB_FIRST), div_cnt=0
  - busy=0, frame_done=0, ser_out=0, load_ready=1 after release
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1
  - on load_valid at a clock edge: data_reg<=load_data, sel<=first index, div_cnt<=0, go SHIFT
- SHIFT:
  - busy=1; ser_out = internal mux output (combinational from data_reg, sel)
  - div_cnt increments each clock; at DIV-1 it wraps to 0 and sel steps (+1, or -1 if MSB_FIRST)
  - Last bit = sel at last index (7, or 0 if MSB_FIRST) with div_cnt==DIV-1
- Latency: first bit visible on ser_out the cycle after handshake. Each bit is held exactly DIV cycles. A frame is 8*DIV cycles.
- End of frame (last bit, div_cnt==DIV-1):
  - frame_done pulses high for the next cycle
  - without a new load: state->IDLE, sel->first index, ser_out->0
- Back-to-back:
  - load_ready is also 1 during the last cycle of the last bit (SHIFT)
  - if load_valid then: new byte captured, stays in SHIFT, sel->first index, no idle gap, busy stays 1, frame_done still pulses
- load_valid while busy and not in last cycle: load_ready=0; input ignored, data_reg unchanged, nothing queued.
- load_data sampled only on handshake; later changes have no effect.
- Reset mid-frame: frame aborted immediately, no frame_done pulse, outputs to reset values.
- DIV=1: sel changes every clock; the div counter degenerates to constant 0.
- Counters are unsigned. sel is 3 bits and wraps naturally, but the FSM never relies on that wrap.

Decomposition:
- Shared package/include:
  - state encoding localparams (IDLE=1'b0, SHIFT=1'b1)
  - SEL_FIRST/SEL_LAST derivation from MSB_FIRST
  - div counter width = 8
- Sub-module: reuse existing mux8to1_12 (hence mux4to1_12, mux_2_12) unchanged as the bit-select datapath. No other sub-module.

Test Plan:
- DIV=1, MSB_FIRST=0, load 0xA5 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 after handshake; sel 0..7; frame_done high cycle 9; busy low cycle 9.
- DIV=3, load 0x81 -> each bit held 3 cycles; ser_out high cycles 1-3 and 22-24, low otherwise; frame_done at cycle 25.
- Back-to-back DIV=1: 0xFF then 0x00, second load_valid held high -> load_ready pulses in cycle 8; ser_out eight 1s then eight 0s, no gap; frame_done at cycles 9 and 17.
- Load attempt during busy: 0x0F accepted, 0xF0 offered at cycle 3 -> load_ready=0, serial stream remains 0x0F pattern.
- rst_n low at cycle 4 of a frame (async, mid-cycle) -> busy, ser_out, frame_done go 0 immediately; sel=0; no frame_done; after release, a new load of 0x3C serialises correctly.
- MSB_FIRST=1, DIV=2, load 0xC0 -> sel 7,7,6,6,...,0,0; ser_out 1,1,1,1 then twelve 0s.
